param_register_file: RTL and testbench

Parametrised successor to the core's 4×8 register file. It provides N-wide, D-deep storage with multiple asynchronous read ports, an optional write-to-read bypass, an optional hardwired-zero register 0, and a fixed tap port. It adds two new features: a one-cycle checkpoint/restore shadow bank, and a valid/ready debug dump engine that streams every register out. The dump engine replaces simulation-only `$display` tracing with a synthesizable observation path. The block sits between decode (read addresses) and writeback (write port), with the dump port wired to the debug interface.

---
 rtl/param_rf_pkg.sv | 12 +
 rtl/rf_dump_ctrl.sv | 67 ++++++
 rtl/param_register_file.sv | 102 ++++++++++
 tb/tb_param_register_file.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/param_rf_pkg.sv
// Shared types and constants for the parametrised register file.
// Holds the dump FSM state encoding and the storage reset value.
package param_rf_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } dump_state_t;

   localparam logic [63:0] RF_RESET_VAL = '0;

endpackage

// File: rtl/rf_dump_ctrl.sv
// Debug dump engine: streams every register out over valid/ready.
// Each beat is captured from the live array at its capture edge.
module rf_dump_ctrl
   import param_rf_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int NREGS = 4,
   localparam int AW = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             start,
   input  logic             ready,
   input  logic [WIDTH-1:0] regs [NREGS],
   output logic             busy,
   output logic             valid,
   output logic             last,
   output logic [AW-1:0]    addr,
   output logic [WIDTH-1:0] data
);

   dump_state_t   state;
   logic [AW-1:0] nxt;
   logic          at_end;

   assign nxt    = addr + AW'(1);
   assign at_end = (addr == AW'(NREGS - 1));
   assign busy   = (state == SEND);

   // Dump FSM with registered beat index, data and flags
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state <= IDLE;
         valid <= 1'b0;
         last  <= 1'b0;
         addr  <= '0;
         data  <= WIDTH'(RF_RESET_VAL);
      end else begin
         unique case (state)
            IDLE: begin
               if (start) begin
                  state <= SEND;
                  valid <= 1'b1;
                  last  <= 1'b0;
                  addr  <= '0;
                  data  <= regs[0];
               end
            end
            SEND: begin
               if (ready) begin
                  if (at_end) begin
                     state <= IDLE;
                     valid <= 1'b0;
                     last  <= 1'b0;
                  end else begin
                     addr <= nxt;
                     data <= regs[nxt];
                     last <= (nxt == AW'(NREGS - 1));
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/param_register_file.sv
// Parametrised register file with bypass, zero register, tap port,
// a one-cycle checkpoint shadow bank and a streaming debug dump.
module param_register_file
   import param_rf_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int NREGS    = 4,
   parameter int NREAD    = 2,
   parameter int TAP_REG  = 1,
   parameter int BYPASS   = 0,
   parameter int ZERO_REG = 0,
   localparam int AW = $clog2(NREGS)
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NREAD*AW-1:0]    rd_addr,
   output logic [NREAD*WIDTH-1:0] rd_data,
   output logic [WIDTH-1:0]       tap_data,
   input  logic                   wr_en,
   input  logic [AW-1:0]          wr_addr,
   input  logic [WIDTH-1:0]       wr_data,
   input  logic                   ckpt_save,
   input  logic                   ckpt_restore,
   input  logic                   dump_start,
   output logic                   dump_busy,
   output logic                   dump_valid,
   input  logic                   dump_ready,
   output logic [AW-1:0]          dump_addr,
   output logic [WIDTH-1:0]       dump_data,
   output logic                   dump_last
);

   logic [WIDTH-1:0] regs   [NREGS];
   logic [WIDTH-1:0] shadow [NREGS];
   logic [WIDTH-1:0] rmap   [2**AW];
   logic             wr_ok;

   // Readable view: unused slots and a hardwired r0 read as zero
   always_comb begin
      for (int k = 0; k < 2**AW; k++) rmap[k] = '0;
      for (int k = 0; k < NREGS; k++)
         if (!(ZERO_REG != 0 && k == 0)) rmap[k] = regs[k];
   end

   // A write counts only if it targets a real, writable register
   always_comb begin
      wr_ok = 1'b0;
      for (int k = 0; k < NREGS; k++)
         if (wr_en && wr_addr == AW'(k) && !(ZERO_REG != 0 && k == 0))
            wr_ok = 1'b1;
   end

   // Asynchronous read ports with optional same-cycle forwarding
   always_comb begin
      rd_data = '0;
      for (int i = 0; i < NREAD; i++) begin
         rd_data[i*WIDTH +: WIDTH] = rmap[rd_addr[i*AW +: AW]];
         if (BYPASS != 0 && wr_ok && wr_addr == rd_addr[i*AW +: AW])
            rd_data[i*WIDTH +: WIDTH] = wr_data;
      end
   end

   assign tap_data = rmap[TAP_REG];

   // Storage and shadow: restore beats write, restore beats save
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int k = 0; k < NREGS; k++) begin
            regs[k]   <= WIDTH'(RF_RESET_VAL);
            shadow[k] <= WIDTH'(RF_RESET_VAL);
         end
      end else begin
         for (int k = 0; k < NREGS; k++) begin
            if (!(ZERO_REG != 0 && k == 0)) begin
               if (ckpt_restore)
                  regs[k] <= shadow[k];
               else if (wr_ok && wr_addr == AW'(k))
                  regs[k] <= wr_data;
            end
            if (ckpt_save && !ckpt_restore)
               shadow[k] <= regs[k];
         end
      end
   end

   rf_dump_ctrl #(
      .WIDTH (WIDTH),
      .NREGS (NREGS)
   ) u_dump (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (dump_start),
      .ready   (dump_ready),
      .regs    (regs),
      .busy    (dump_busy),
      .valid   (dump_valid),
      .last    (dump_last),
      .addr    (dump_addr),
      .data    (dump_data)
   );

endmodule

// File: tb/tb_param_register_file.sv
// Directed bench for param_register_file: default, bypass and
// zero-register instances share stimulus and are checked in parallel.
module tb_param_register_file;

   logic       clk;
   logic       reset_n;
   logic [3:0] rd_addr;
   logic       wr_en;
   logic [1:0] wr_addr;
   logic [7:0] wr_data;
   logic       ckpt_save;
   logic       ckpt_restore;
   logic       dump_start;
   logic       dump_ready;

   logic [15:0] rd_a, rd_b, rd_z;
   logic [7:0]  tap_a, tap_b, tap_z;
   logic        busy_a, busy_b, busy_z;
   logic        val_a, val_b, val_z;
   logic [1:0]  dad_a, dad_b, dad_z;
   logic [7:0]  dd_a, dd_b, dd_z;
   logic        last_a, last_b, last_z;

   int n_cmp = 0;
   int n_bad = 0;

   param_register_file dut (
      .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_a),
      .tap_data(tap_a), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .ckpt_save(ckpt_save),
      .ckpt_restore(ckpt_restore), .dump_start(dump_start),
      .dump_busy(busy_a), .dump_valid(val_a), .dump_ready(dump_ready),
      .dump_addr(dad_a), .dump_data(dd_a), .dump_last(last_a)
   );

   param_register_file #(.BYPASS(1)) dut_b (
      .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_b),
      .tap_data(tap_b), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .ckpt_save(ckpt_save),
      .ckpt_restore(ckpt_restore), .dump_start(dump_start),
      .dump_busy(busy_b), .dump_valid(val_b), .dump_ready(dump_ready),
      .dump_addr(dad_b), .dump_data(dd_b), .dump_last(last_b)
   );

   param_register_file #(.ZERO_REG(1)) dut_z (
      .clk(clk), .reset_n(reset_n), .rd_addr(rd_addr), .rd_data(rd_z),
      .tap_data(tap_z), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_data(wr_data), .ckpt_save(ckpt_save),
      .ckpt_restore(ckpt_restore), .dump_start(dump_start),
      .dump_busy(busy_z), .dump_valid(val_z), .dump_ready(dump_ready),
      .dump_addr(dad_z), .dump_data(dd_z), .dump_last(last_z)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      logic       we;
      logic [1:0] wa;
      logic [7:0] wd;
      logic [1:0] ra0;
      logic [1:0] ra1;
      logic [7:0] e0;
      logic [7:0] e1;
      logic [7:0] etap;
      logic [7:0] eb0;
      logic [7:0] eb1;
   } vec_t;

   vec_t vecs [5];

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic do_wr(input logic [1:0] a, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_addr = a;
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   task automatic rd2(input logic [1:0] a0, input logic [1:0] a1);
      rd_addr = {a1, a0};
      #1;
   endtask

   logic [7:0] exp_d [6];
   logic [1:0] exp_a [6];
   logic       exp_l [6];
   logic       pat   [6];

   initial begin
      vecs[0] = '{1'b1, 2'd2, 8'hA5, 2'd2, 2'd1,
                  8'h00, 8'h00, 8'h00, 8'hA5, 8'h00};
      vecs[1] = '{1'b1, 2'd1, 8'h3C, 2'd2, 2'd1,
                  8'hA5, 8'h00, 8'h00, 8'hA5, 8'h3C};
      vecs[2] = '{1'b0, 2'd0, 8'h00, 2'd2, 2'd1,
                  8'hA5, 8'h3C, 8'h3C, 8'hA5, 8'h3C};
      vecs[3] = '{1'b1, 2'd3, 8'h77, 2'd3, 2'd3,
                  8'h00, 8'h00, 8'h3C, 8'h77, 8'h77};
      vecs[4] = '{1'b0, 2'd0, 8'h00, 2'd3, 2'd0,
                  8'h77, 8'h00, 8'h3C, 8'h77, 8'h00};

      exp_d = '{8'h10, 8'h20, 8'h20, 8'h20, 8'h30, 8'h40};
      exp_a = '{2'd0, 2'd1, 2'd1, 2'd1, 2'd2, 2'd3};
      exp_l = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      pat   = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};

      reset_n      = 1'b1;
      rd_addr      = 4'b0110;
      wr_en        = 1'b0;
      wr_addr      = '0;
      wr_data      = '0;
      ckpt_save    = 1'b0;
      ckpt_restore = 1'b0;
      dump_start   = 1'b0;
      dump_ready   = 1'b0;

      #2 reset_n = 1'b0;
      #1;
      chk("reset_rd", 32'(rd_a), 32'h0);
      chk("reset_tap", 32'(tap_a), 32'h0);
      chk("reset_valid", 32'(val_a), 32'h0);
      chk("reset_busy", 32'(busy_a), 32'h0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);

      // write/read/bypass table
      for (int i = 0; i < 5; i++) begin
         rd_addr = {vecs[i].ra1, vecs[i].ra0};
         wr_en   = vecs[i].we;
         wr_addr = vecs[i].wa;
         wr_data = vecs[i].wd;
         #1;
         chk($sformatf("v%0d_rd0", i), 32'(rd_a[7:0]), 32'(vecs[i].e0));
         chk($sformatf("v%0d_rd1", i), 32'(rd_a[15:8]), 32'(vecs[i].e1));
         chk($sformatf("v%0d_tap", i), 32'(tap_a), 32'(vecs[i].etap));
         chk($sformatf("v%0d_byp0", i), 32'(rd_b[7:0]), 32'(vecs[i].eb0));
         chk($sformatf("v%0d_byp1", i), 32'(rd_b[15:8]), 32'(vecs[i].eb1));
         @(negedge clk);
      end
      wr_en = 1'b0;

      // checkpoint with concurrent writes
      do_wr(2'd0, 8'h01);
      do_wr(2'd1, 8'h02);
      do_wr(2'd2, 8'h03);
      do_wr(2'd3, 8'h04);
      ckpt_save = 1'b1;
      do_wr(2'd0, 8'hFF);
      ckpt_save = 1'b0;
      do_wr(2'd1, 8'h99);
      rd2(2'd0, 2'd1);
      chk("pre_restore_r0", 32'(rd_a[7:0]), 32'h FF);
      chk("pre_restore_r1", 32'(rd_a[15:8]), 32'h99);
      chk("zero_r0_write", 32'(rd_z[7:0]), 32'h00);
      ckpt_restore = 1'b1;
      do_wr(2'd2, 8'h55);
      ckpt_restore = 1'b0;
      rd2(2'd0, 2'd1);
      chk("restore_r0", 32'(rd_a[7:0]), 32'h01);
      chk("restore_r1", 32'(rd_a[15:8]), 32'h02);
      chk("zero_r0_restore", 32'(rd_z[7:0]), 32'h00);
      rd2(2'd2, 2'd3);
      chk("restore_r2", 32'(rd_a[7:0]), 32'h03);
      chk("restore_r3", 32'(rd_a[15:8]), 32'h04);
      @(negedge clk);

      // dump with backpressure and a stray restart
      do_wr(2'd0, 8'h10);
      do_wr(2'd1, 8'h20);
      do_wr(2'd2, 8'h30);
      do_wr(2'd3, 8'h40);
      dump_start = 1'b1;
      @(negedge clk);
      dump_start = 1'b0;
      for (int c = 0; c < 6; c++) begin
         dump_ready = pat[c];
         dump_start = (c == 1);
         #1;
         chk($sformatf("dump%0d_valid", c), 32'(val_a), 32'h1);
         chk($sformatf("dump%0d_busy", c), 32'(busy_a), 32'h1);
         chk($sformatf("dump%0d_data", c), 32'(dd_a), 32'(exp_d[c]));
         chk($sformatf("dump%0d_addr", c), 32'(dad_a), 32'(exp_a[c]));
         chk($sformatf("dump%0d_last", c), 32'(last_a), 32'(exp_l[c]));
         if (c == 0) chk("zero_dump_first", 32'(dd_z), 32'h00);
         @(negedge clk);
      end
      dump_start = 1'b0;
      dump_ready = 1'b0;
      #1;
      chk("dump_end_valid", 32'(val_a), 32'h0);
      chk("dump_end_busy", 32'(busy_a), 32'h0);
      @(negedge clk);

      // async reset mid-dump on the last beat
      dump_start = 1'b1;
      @(negedge clk);
      dump_start = 1'b0;
      dump_ready = 1'b1;
      repeat (3) @(negedge clk);
      dump_ready = 1'b0;
      rd_addr = {2'd3, 2'd2};
      #1;
      chk("pre_rst_last", 32'(last_a), 32'h1);
      chk("pre_rst_data", 32'(dd_a), 32'h40);
      #1 reset_n = 1'b0;
      #1;
      chk("rst_rd", 32'(rd_a), 32'h0);
      chk("rst_tap", 32'(tap_a), 32'h0);
      chk("rst_valid", 32'(val_a), 32'h0);
      chk("rst_busy", 32'(busy_a), 32'h0);
      chk("rst_last", 32'(last_a), 32'h0);
      chk("rst_addr", 32'(dad_a), 32'h0);
      chk("rst_data", 32'(dd_a), 32'h0);
      dump_start = 1'b1;
      @(negedge clk);
      dump_start = 1'b0;
      reset_n = 1'b1;
      @(negedge clk);
      #1;
      chk("lost_start_valid", 32'(val_a), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
